// File: rtl/sdram_host_port.sv
// rtl/sdram_host_port.sv - host request queue and one-at-a-time issue FSM for an SDRAM controller; SDRAM_HOST_PORT_WR_ACK_EN adds wr_done
module sdram_host_port #(
  parameter int ADDR_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // host request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  // host response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_rdata,
  // controller request side
  output logic                  ctl_wr_enable,
  output logic                  ctl_rd_enable,
  output logic [ADDR_WIDTH-1:0] ctl_wr_addr,
  output logic [ADDR_WIDTH-1:0] ctl_rd_addr,
  output logic [15:0]           ctl_wr_data,
  // controller status/return side
  input  logic                  ctl_busy,
  input  logic                  ctl_rd_ready,
  input  logic [15:0]           ctl_rd_data
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
  ,
  output logic                  wr_done
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + 16;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // request queue storage and pointers (extra MSB distinguishes full from empty)
  logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    head;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [15:0]           head_wdata;

  // issue register, FSM and response holding register
  state_e                state_q, state_d;
  logic                  iss_we_q, iss_we_d;
  logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
  logic [15:0]           iss_data_q, iss_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [15:0]           rsp_rdata_q, rsp_rdata_d;
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
  logic                  wr_done_q, wr_done_d;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // req_ready depends only on registered pointers, so a same-cycle pop never frees a slot early
  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_we    = head[ENTRY_W-1];
  assign head_addr  = head[ENTRY_W-2 -: ADDR_WIDTH];
  assign head_wdata = head[15:0];

  // a read may not start while the previous read's data is still waiting for the host
  assign pop = (state_q == IDLE) && !fifo_empty && !(!head_we && rsp_valid_q);

  // next-state for the queue pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // queue storage: write the pushed entry into its slot
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {req_we, req_addr, req_wdata};
  end

  // queue pointers; reset empties the queue and drops everything pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // next-state for the issue FSM, issue register and response register
  always_comb begin
    state_d     = state_q;
    iss_we_d    = iss_we_q;
    iss_addr_d  = iss_addr_q;
    iss_data_d  = iss_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
    wr_done_d   = 1'b0;
`endif
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          iss_we_d   = head_we;
          iss_addr_d = head_addr;
          iss_data_d = head_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // hold the enable for as long as the controller ignores it (e.g. refresh)
        if (ctl_busy) state_d = ACTIVE;
      end
      ACTIVE: begin
        // read data and busy falling together are both honoured in this cycle
        if (ctl_rd_ready && !iss_we_q) begin
          rsp_rdata_d = ctl_rd_data;
          rsp_valid_d = 1'b1;
        end
        if (!ctl_busy) begin
          state_d = IDLE;
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
          wr_done_d = iss_we_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // issue FSM with registered issue/response state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
      wr_done_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      iss_we_q    <= iss_we_d;
      iss_addr_q  <= iss_addr_d;
      iss_data_q  <= iss_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
      wr_done_q   <= wr_done_d;
`endif
    end
  end

  // enables drop in the same cycle busy rises; only one can be high since iss_we_q selects
  assign ctl_wr_enable = (state_q == ISSUE) &&  iss_we_q && !ctl_busy;
  assign ctl_rd_enable = (state_q == ISSUE) && !iss_we_q && !ctl_busy;
  assign ctl_wr_addr   = iss_addr_q;
  assign ctl_rd_addr   = iss_addr_q;
  assign ctl_wr_data   = iss_data_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
  assign wr_done   = wr_done_q;
`endif

endmodule

// File: tb/tb_sdram_host_port.sv
// tb/tb_sdram_host_port.sv - directed self-checking bench for sdram_host_port
`timescale 1ns/1ps
module tb_sdram_host_port;

  localparam int AW    = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_rdata;
  logic          ctl_wr_enable;
  logic          ctl_rd_enable;
  logic [AW-1:0] ctl_wr_addr;
  logic [AW-1:0] ctl_rd_addr;
  logic [15:0]   ctl_wr_data;
  logic          ctl_busy;
  logic          ctl_rd_ready;
  logic [15:0]   ctl_rd_data;
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
  logic          wr_done;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sdram_host_port #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ctl_wr_enable(ctl_wr_enable),
    .ctl_rd_enable(ctl_rd_enable),
    .ctl_wr_addr(ctl_wr_addr),
    .ctl_rd_addr(ctl_rd_addr),
    .ctl_wr_data(ctl_wr_data),
    .ctl_busy(ctl_busy),
    .ctl_rd_ready(ctl_rd_ready),
    .ctl_rd_data(ctl_rd_data)
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
    ,
    .wr_done(wr_done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [15:0] d, output bit ok);
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (ctl_wr_enable || ctl_rd_enable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // controller model: accept one request, busy for one cycle, read data returned as busy falls
  task automatic serve(input logic [15:0] ret, output bit ok, output logic we,
                       output logic [AW-1:0] a, output logic [15:0] d);
    we = 1'b0;
    a  = '0;
    d  = '0;
    wait_en(ok);
    if (!ok) return;
    we = ctl_wr_enable;
    a  = we ? ctl_wr_addr : ctl_rd_addr;
    d  = ctl_wr_data;
    ctl_busy = 1'b1;
    tick();
    ctl_busy     = 1'b0;
    ctl_rd_ready = !we;
    ctl_rd_data  = ret;
    tick();
    ctl_rd_ready = 1'b0;
    ctl_rd_data  = 16'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin
      n_err++; $display("FAIL reset_rsp: got valid=%b rdata=%h expected 0/0000", rsp_valid, rsp_rdata);
    end
    n_cmp++;
    if ({ctl_wr_enable, ctl_rd_enable} !== 2'b00 || ctl_wr_addr !== '0 || ctl_rd_addr !== '0 || ctl_wr_data !== 16'h0) begin
      n_err++; $display("FAIL reset_ctl: got en=%b%b waddr=%h raddr=%h wdata=%h expected all 0",
                        ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_rd_addr, ctl_wr_data);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    int hi;
    push(1'b1, 24'h012345, 16'hBEEF, ok);
    wait_en(ok);
    n_cmp++;
    if (!ok || ctl_wr_enable !== 1'b1 || ctl_rd_enable !== 1'b0) begin
      n_err++; $display("FAIL wr_enable_seen: got wr=%b rd=%b expected wr=1 rd=0", ctl_wr_enable, ctl_rd_enable);
    end
    n_cmp++;
    if (ctl_wr_addr !== 24'h012345 || ctl_wr_data !== 16'hBEEF) begin
      n_err++; $display("FAIL wr_addr_data: got %h/%h expected 012345/beef", ctl_wr_addr, ctl_wr_data);
    end
    hi = ctl_wr_enable ? 1 : 0;
    tick();
    #1;
    if (ctl_wr_enable) hi++;
    tick();
    ctl_busy = 1'b1;
    #1;
    if (ctl_wr_enable) hi++;
    n_cmp++;
    if (hi != 2) begin n_err++; $display("FAIL wr_enable_cycles: got %0d expected 2", hi); end
    tick();
    ctl_busy = 1'b0;
    tick();
`ifdef SDRAM_HOST_PORT_WR_ACK_EN
    #1;
    n_cmp++;
    if (wr_done !== 1'b1) begin n_err++; $display("FAIL wr_done_pulse: got %b expected 1", wr_done); end
    tick();
    #1;
    n_cmp++;
    if (wr_done !== 1'b0) begin n_err++; $display("FAIL wr_done_clear: got %b expected 0", wr_done); end
`endif
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || ctl_wr_enable !== 1'b0 || ctl_rd_enable !== 1'b0) begin
      n_err++; $display("FAIL wr_idle_after: got ready=%b en=%b%b expected 1/00", req_ready, ctl_wr_enable, ctl_rd_enable);
    end
    tick();
  endtask

  task automatic test_read();
    bit ok;
    int bad;
    push(1'b0, 24'h000010, 16'h0, ok);
    wait_en(ok);
    n_cmp++;
    if (!ok || ctl_rd_enable !== 1'b1 || ctl_wr_enable !== 1'b0 || ctl_rd_addr !== 24'h000010) begin
      n_err++; $display("FAIL rd_issue: got rd=%b wr=%b addr=%h expected 1/0/000010", ctl_rd_enable, ctl_wr_enable, ctl_rd_addr);
    end
    ctl_busy = 1'b1;
    #1;
    n_cmp++;
    if (ctl_rd_enable !== 1'b0) begin n_err++; $display("FAIL rd_drop_on_busy: got %b expected 0", ctl_rd_enable); end
    tick();
    ctl_rd_ready = 1'b1;
    ctl_rd_data  = 16'h1234;
    tick();
    ctl_rd_ready = 1'b0;
    ctl_rd_data  = 16'hDEAD;
    ctl_busy     = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL rd_rsp_hold: got %0d bad cycles, rdata=%h expected 0 bad, 1234", bad, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_clear: got %b expected 0", rsp_valid); end
    ctl_rd_data = 16'h0;
    tick();
  endtask

  task automatic test_refresh();
    bit ok;
    int hi;
    int extra;
    push(1'b1, 24'h0ABCDE, 16'h5555, ok);
    wait_en(ok);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (ctl_wr_enable && ctl_wr_addr == 24'h0ABCDE) hi++;
      tick();
      #1;
    end
    ctl_busy = 1'b1;
    #1;
    n_cmp++;
    if (hi != 12) begin n_err++; $display("FAIL refresh_hold: got %0d cycles expected 12", hi); end
    n_cmp++;
    if (ctl_wr_enable !== 1'b0) begin n_err++; $display("FAIL refresh_drop: got %b expected 0", ctl_wr_enable); end
    tick();
    ctl_busy = 1'b0;
    tick();
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ctl_wr_enable || ctl_rd_enable) extra++;
      tick();
    end
    n_cmp++;
    if (extra != 0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL refresh_single: got %0d extra enable cycles ready=%b expected 0/1", extra, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit acc;
    logic [4:0] rdy;
    int bad;
    logic we;
    logic [AW-1:0] a;
    logic [15:0] d;
    push(1'b1, 24'h000300, 16'h0300, ok);
    wait_en(ok);
    ctl_busy = 1'b1;
    tick();
    rdy = '0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 24'h000100 + AW'(k);
      req_wdata = 16'hA000 + 16'(k);
      #1;
      rdy[k] = req_ready;
      tick();
    end
    n_cmp++;
    if (rdy !== 5'b01111) begin n_err++; $display("FAIL full_ready_seq: got %b expected 01111", rdy); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (req_ready !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL full_stall: got %0d ready cycles expected 0", bad); end
    ctl_busy = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) tick();
    req_valid = 1'b0;
    n_cmp++;
    if (!acc) begin n_err++; $display("FAIL full_fifth_accept: got 0 expected 1"); end
    for (int k = 0; k < 5; k++) begin
      serve(16'h0, ok, we, a, d);
      n_cmp++;
      if (!ok || we !== 1'b1 || a !== 24'h000100 + AW'(k) || d !== 16'hA000 + 16'(k)) begin
        n_err++; $display("FAIL order_%0d: got ok=%0d we=%b addr=%h data=%h expected 1/1/%h/%h",
                          k, ok, we, a, d, 24'h000100 + AW'(k), 16'hA000 + 16'(k));
      end
    end
  endtask

  task automatic test_rsp_block();
    bit ok;
    int en_seen;
    int bad;
    logic we;
    logic [AW-1:0] a;
    logic [15:0] d;
    push(1'b0, 24'h000200, 16'h0, ok);
    push(1'b0, 24'h000201, 16'h0, ok);
    push(1'b1, 24'h000202, 16'h7777, ok);
    serve(16'h1111, ok, we, a, d);
    n_cmp++;
    if (!ok || we !== 1'b0 || a !== 24'h000200) begin
      n_err++; $display("FAIL blk_first_read: got ok=%0d we=%b addr=%h expected 1/0/000200", ok, we, a);
    end
    en_seen = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ctl_wr_enable || ctl_rd_enable) en_seen++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1111) bad++;
      tick();
    end
    n_cmp++;
    if (en_seen != 0) begin n_err++; $display("FAIL blk_no_enable: got %0d enable cycles expected 0", en_seen); end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL blk_rsp_hold: got %0d bad cycles expected 0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    serve(16'h2222, ok, we, a, d);
    n_cmp++;
    if (!ok || we !== 1'b0 || a !== 24'h000201) begin
      n_err++; $display("FAIL blk_second_read: got ok=%0d we=%b addr=%h expected 1/0/000201", ok, we, a);
    end
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h2222) begin
      n_err++; $display("FAIL blk_second_data: got %b/%h expected 1/2222", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    serve(16'h0, ok, we, a, d);
    n_cmp++;
    if (!ok || we !== 1'b1 || a !== 24'h000202 || d !== 16'h7777) begin
      n_err++; $display("FAIL blk_write_last: got ok=%0d we=%b addr=%h data=%h expected 1/1/000202/7777", ok, we, a, d);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int en;
    logic we;
    logic [AW-1:0] a;
    logic [15:0] d;
    push(1'b0, 24'h000400, 16'h0, ok);
    serve(16'h4321, ok, we, a, d);
    push(1'b1, 24'h000401, 16'h0001, ok);
    wait_en(ok);
    ctl_busy = 1'b1;
    tick();
    push(1'b1, 24'h000402, 16'h0002, ok);
    push(1'b1, 24'h000403, 16'h0003, ok);
    push(1'b1, 24'h000404, 16'h0004, ok);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h4321) begin
      n_err++; $display("FAIL rstmid_pre_rsp: got %b/%h expected 1/4321", rsp_valid, rsp_rdata);
    end
    rst_n    = 1'b0;
    ctl_busy = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ctl_wr_enable !== 1'b0 || ctl_rd_enable !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state: got ready=%b rsp=%b en=%b%b expected 1/0/00",
                        req_ready, rsp_valid, ctl_wr_enable, ctl_rd_enable);
    end
    rst_n = 1'b1;
    en = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if (ctl_wr_enable || ctl_rd_enable || rsp_valid) en++;
    end
    n_cmp++;
    if (en != 0) begin n_err++; $display("FAIL rstmid_dropped: got %0d active cycles expected 0", en); end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = 16'h0;
    rsp_ready    = 1'b0;
    ctl_busy     = 1'b0;
    ctl_rd_ready = 1'b0;
    ctl_rd_data  = 16'h0;
    test_reset();
    test_single_write();
    test_read();
    test_refresh();
    test_back_to_back();
    test_rsp_block();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
